// File: rtl/hazard_pkg.sv
// Shared types for the RV32 pipeline hazard controller: FSM state codes,
// EX operand forward selects and the hard-wired zero register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard observation inputs and stage control outputs between the pipeline
// (master) and the hazard controller (slave).
interface hazard_ctrl_if;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rd;
  logic       ex_reg_wr;
  logic       ex_mem_load;
  logic [4:0] mem_rd;
  logic       mem_reg_wr;
  logic       ex_redirect;
  logic       imem_ack;
  logic       dmem_req;
  logic       dmem_ack;

  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_m_en;
  logic       m_wb_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       m_wb_bubble;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [1:0] state;
  logic       mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_reg_wr, ex_mem_load, mem_rd, mem_reg_wr,
    output ex_redirect, imem_ack, dmem_req, dmem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en,
    input  if_id_flush, id_ex_flush, m_wb_bubble,
    input  fwd_a, fwd_b, state, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_reg_wr, ex_mem_load, mem_rd, mem_reg_wr,
    input  ex_redirect, imem_ack, dmem_req, dmem_ack,
    output pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en,
    output if_id_flush, id_ex_flush, m_wb_bubble,
    output fwd_a, fwd_b, state, mem_timeout
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Forward select for one EX operand: EX/MEM result beats MEM/WB value, x0 never
// forwarded. Purely combinational, no backpressure.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_wr,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_wr,
  output fwd_sel_e   sel
);

  always_comb begin
    sel = FWD_RF;
    if (rs != REG_ZERO) begin
      if (ex_reg_wr && (ex_rd == rs)) begin
        sel = FWD_MEM;
      end else if (mem_reg_wr && (mem_rd == rs)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: stage enables/flushes are same-cycle combinational, forward selects registered into EX;
// stalls on dmem wait, load-use and imem wait. HAZARD_CTRL_PERF_EN adds 32-bit stall/redirect counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_stall,
  output logic [31:0]  perf_flush
`endif
);

  localparam int CW = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;

  localparam logic [1:0] S_RUN      = RUN;
  localparam logic [1:0] S_LOAD_USE = LOAD_USE;
  localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] S_REDIRECT = REDIRECT;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [1:0]    fwd_a_q;
  logic [1:0]    fwd_b_q;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] cnt_inc;
  logic          mem_timeout;
  logic          timeout_hit;

  logic dmem_wait;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_m_en;
  logic m_wb_en;
  logic if_id_flush;
  logic id_ex_flush;
  logic m_wb_bubble;

  fwd_sel_e sel_a;
  fwd_sel_e sel_b;

  assign dmem_wait = hz.dmem_req & ~hz.dmem_ack;
  assign rs1_hit   = hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd);
  assign rs2_hit   = hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd);
  assign load_use  = hz.ex_mem_load & hz.ex_reg_wr & (hz.ex_rd != REG_ZERO) & (rs1_hit | rs2_hit);

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_m_en     = 1'b1;
    m_wb_en     = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    m_wb_bubble = 1'b0;
    state_nxt   = S_RUN;

    if (dmem_wait) begin
      // Everything up to EX/MEM freezes; WB keeps draining with bubbles.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_m_en     = 1'b0;
      m_wb_bubble = 1'b1;
      state_nxt   = S_MEM_WAIT;
    end else if (hz.ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_nxt   = S_REDIRECT;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      state_nxt   = S_LOAD_USE;
    end else if (!hz.imem_ack) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end

    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_m_en     = 1'b0;
      m_wb_en     = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      m_wb_bubble = 1'b0;
    end
  end

  hazard_fwd_sel u_fwd_a (
    .rs         (hz.id_rs1),
    .ex_rd      (hz.ex_rd),
    .ex_reg_wr  (hz.ex_reg_wr),
    .mem_rd     (hz.mem_rd),
    .mem_reg_wr (hz.mem_reg_wr),
    .sel        (sel_a)
  );

  hazard_fwd_sel u_fwd_b (
    .rs         (hz.id_rs2),
    .ex_rd      (hz.ex_rd),
    .ex_reg_wr  (hz.ex_reg_wr),
    .mem_rd     (hz.mem_rd),
    .mem_reg_wr (hz.mem_reg_wr),
    .sel        (sel_b)
  );

  // Counts every cycle spent stalled on dmem (entry cycle included) and saturates.
  assign cnt_inc     = (&wait_cnt) ? wait_cnt : wait_cnt + CW'(1);
  assign timeout_hit = dmem_wait && (cnt_inc >= CW'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= dmem_wait ? cnt_inc : '0;
      if (timeout_hit) begin
        mem_timeout <= 1'b1;
      end
      if (id_ex_flush) begin
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
      end else if (id_ex_en) begin
        fwd_a_q <= sel_a;
        fwd_b_q <= sel_b;
      end
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic redirect_evt;

  assign redirect_evt = hz.ex_redirect & ~dmem_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (!pc_en) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (redirect_evt) begin
        perf_flush <= perf_flush + 32'd1;
      end
    end
  end
`endif

  assign hz.pc_en       = pc_en;
  assign hz.if_id_en    = if_id_en;
  assign hz.id_ex_en    = id_ex_en;
  assign hz.ex_m_en     = ex_m_en;
  assign hz.m_wb_en     = m_wb_en;
  assign hz.if_id_flush = if_id_flush;
  assign hz.id_ex_flush = id_ex_flush;
  assign hz.m_wb_bubble = m_wb_bubble;
  assign hz.fwd_a       = fwd_a_q;
  assign hz.fwd_b       = fwd_b_q;
  assign hz.state       = state;
  assign hz.mem_timeout = mem_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MAX_WAIT=3): single-cycle vector table plus
// multi-cycle sequences for load-use, dmem wait, timeout, reset and redirect.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  hazard_ctrl_if hz();

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  hazard_ctrl #(.MAX_WAIT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .hz         (hz)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      nm;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] exrd;
    logic       exwr;
    logic       exld;
    logic [4:0] memrd;
    logic       memwr;
    logic       redir;
    logic       iack;
    logic [7:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(string nm, int rs1, int rs2, int u1, int u2, int exrd, int exwr, int exld,
                              int memrd, int memwr, int redir, int iack, int ctl, int fa, int fb, int st);
    vec_t v;
    v.nm    = nm;
    v.rs1   = 5'(rs1);
    v.rs2   = 5'(rs2);
    v.u1    = u1[0];
    v.u2    = u2[0];
    v.exrd  = 5'(exrd);
    v.exwr  = exwr[0];
    v.exld  = exld[0];
    v.memrd = 5'(memrd);
    v.memwr = memwr[0];
    v.redir = redir[0];
    v.iack  = iack[0];
    v.ctl   = 8'(ctl);
    v.fa    = 2'(fa);
    v.fb    = 2'(fb);
    v.st    = 2'(st);
    return v;
  endfunction

  // {pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en, if_id_flush, id_ex_flush, m_wb_bubble}
  function automatic logic [7:0] ctl();
    return {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_m_en, hz.m_wb_en,
            hz.if_id_flush, hz.id_ex_flush, hz.m_wb_bubble};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    hz.id_rs1      = 5'd1;
    hz.id_rs2      = 5'd2;
    hz.id_use_rs1  = 1'b1;
    hz.id_use_rs2  = 1'b1;
    hz.ex_rd       = 5'd0;
    hz.ex_reg_wr   = 1'b0;
    hz.ex_mem_load = 1'b0;
    hz.mem_rd      = 5'd0;
    hz.mem_reg_wr  = 1'b0;
    hz.ex_redirect = 1'b0;
    hz.imem_ack    = 1'b1;
    hz.dmem_req    = 1'b0;
    hz.dmem_ack    = 1'b0;
  endtask

  task automatic apply(vec_t v);
    set_idle();
    hz.id_rs1      = v.rs1;
    hz.id_rs2      = v.rs2;
    hz.id_use_rs1  = v.u1;
    hz.id_use_rs2  = v.u2;
    hz.ex_rd       = v.exrd;
    hz.ex_reg_wr   = v.exwr;
    hz.ex_mem_load = v.exld;
    hz.mem_rd      = v.memrd;
    hz.mem_reg_wr  = v.memwr;
    hz.ex_redirect = v.redir;
    hz.imem_ack    = v.iack;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    //                 name          rs1 rs2 u1 u2 exrd wr ld memrd wr rdr iack ctl   fa fb st
    vecs[0]  = mk("idle",           1,  2,  1, 1, 0,   0, 0, 0,    0, 0,  1,  'hF8, 0, 0, 0);
    vecs[1]  = mk("ex_fwd_both",    3,  3,  1, 1, 3,   1, 0, 0,    0, 0,  1,  'hF8, 1, 1, 0);
    vecs[2]  = mk("ex_over_mem",    7,  3,  1, 1, 3,   1, 0, 3,    1, 0,  1,  'hF8, 0, 1, 0);
    vecs[3]  = mk("rd_zero",        0,  0,  1, 1, 0,   1, 0, 0,    1, 0,  1,  'hF8, 0, 0, 0);
    vecs[4]  = mk("wb_fwd_a",       9,  4,  1, 1, 4,   0, 0, 9,    1, 0,  1,  'hF8, 2, 0, 0);
    vecs[5]  = mk("wb_fwd_b",       6,  9,  1, 1, 6,   1, 0, 9,    1, 0,  1,  'hF8, 1, 2, 0);
    vecs[6]  = mk("mem_no_wr",      9,  9,  1, 1, 0,   0, 0, 9,    0, 0,  1,  'hF8, 0, 0, 0);
    vecs[7]  = mk("load_use_rs2",   1,  8,  1, 1, 8,   1, 1, 0,    0, 0,  1,  'h3A, 0, 0, 1);
    vecs[8]  = mk("load_rs2_unused",1,  8,  1, 0, 8,   1, 1, 0,    0, 0,  1,  'hF8, 0, 1, 0);
    vecs[9]  = mk("load_x0",        0,  0,  1, 1, 0,   1, 1, 0,    0, 0,  1,  'hF8, 0, 0, 0);
    vecs[10] = mk("imem_wait",      1,  2,  1, 1, 0,   0, 0, 0,    0, 0,  0,  'h7C, 0, 0, 0);
    vecs[11] = mk("lu_and_imem",    5,  2,  1, 1, 5,   1, 1, 0,    0, 0,  0,  'h3A, 0, 0, 1);
    vecs[12] = mk("redirect",       3,  2,  1, 1, 3,   1, 0, 0,    0, 1,  1,  'hFE, 0, 0, 3);
    vecs[13] = mk("redir_over_lu",  5,  2,  1, 1, 5,   1, 1, 0,    0, 1,  1,  'hFE, 0, 0, 3);
    vecs[14] = mk("redir_imem",     1,  2,  1, 1, 0,   0, 0, 0,    0, 1,  0,  'hFE, 0, 0, 3);

    rst = 1'b1;
    set_idle();
    tick();
    tick();
    #2;
    chk("rst_ctl", 32'(ctl()), 32'h0);
    chk("rst_state", 32'(hz.state), 32'd0);
    chk("rst_fwd_a", 32'(hz.fwd_a), 32'd0);
    chk("rst_fwd_b", 32'(hz.fwd_b), 32'd0);
    chk("rst_timeout", 32'(hz.mem_timeout), 32'd0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i]);
      #2;
      chk({vecs[i].nm, "_ctl"}, 32'(ctl()), 32'(vecs[i].ctl));
      tick();
      chk({vecs[i].nm, "_fwd_a"}, 32'(hz.fwd_a), 32'(vecs[i].fa));
      chk({vecs[i].nm, "_fwd_b"}, 32'(hz.fwd_b), 32'(vecs[i].fb));
      chk({vecs[i].nm, "_state"}, 32'(hz.state), 32'(vecs[i].st));
    end

    // Load-use: one bubble, then the load in MEM forwards via WB path.
    set_idle();
    hz.ex_mem_load = 1'b1;
    hz.ex_reg_wr   = 1'b1;
    hz.ex_rd       = 5'd5;
    hz.id_rs1      = 5'd5;
    #2;
    chk("lu_pc_en", 32'(hz.pc_en), 32'd0);
    chk("lu_id_ex_flush", 32'(hz.id_ex_flush), 32'd1);
    tick();
    chk("lu_state", 32'(hz.state), 32'd1);
    hz.ex_mem_load = 1'b0;
    hz.ex_reg_wr   = 1'b0;
    hz.ex_rd       = 5'd0;
    hz.mem_rd      = 5'd5;
    hz.mem_reg_wr  = 1'b1;
    #2;
    chk("lu2_pc_en", 32'(hz.pc_en), 32'd1);
    chk("lu2_id_ex_flush", 32'(hz.id_ex_flush), 32'd0);
    tick();
    chk("lu2_fwd_a", 32'(hz.fwd_a), 32'd2);
    chk("lu2_state", 32'(hz.state), 32'd0);

    // Four-cycle dmem wait; the forward select must hold while ID/EX is frozen.
    set_idle();
    hz.id_rs1    = 5'd3;
    hz.ex_rd     = 5'd3;
    hz.ex_reg_wr = 1'b1;
    tick();
    chk("pre_wait_fwd_a", 32'(hz.fwd_a), 32'd1);
    set_idle();
    hz.id_rs1   = 5'd0;
    hz.dmem_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("wait_ctl", 32'(ctl()), 32'h09);
      tick();
      chk("wait_state", 32'(hz.state), 32'd2);
    end
    chk("wait_fwd_hold", 32'(hz.fwd_a), 32'd1);
    hz.dmem_ack = 1'b1;
    #2;
    chk("ack_ctl", 32'(ctl()), 32'hF8);
    tick();
    chk("ack_state", 32'(hz.state), 32'd0);
    chk("ack_fwd_a", 32'(hz.fwd_a), 32'd0);
    chk("wait4_timeout", 32'(hz.mem_timeout), 32'd1);
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clears_timeout", 32'(hz.mem_timeout), 32'd0);

    // Ack withheld five cycles: timeout sets on the third, is sticky until reset.
    hz.dmem_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("timeout_wait%0d", k), 32'(hz.mem_timeout), (k >= 3) ? 32'd1 : 32'd0);
    end
    hz.dmem_ack = 1'b1;
    tick();
    chk("timeout_after_ack", 32'(hz.mem_timeout), 32'd1);
    set_idle();
    tick();
    tick();
    chk("timeout_sticky", 32'(hz.mem_timeout), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("timeout_rst", 32'(hz.mem_timeout), 32'd0);
    chk("timeout_rst_state", 32'(hz.state), 32'd0);

    // Reset in the middle of MEM_WAIT must also clear the wait counter.
    hz.dmem_req = 1'b1;
    tick();
    tick();
    chk("midwait_state", 32'(hz.state), 32'd2);
    rst = 1'b1;
    #2;
    chk("midwait_rst_ctl", 32'(ctl()), 32'h0);
    tick();
    rst = 1'b0;
    chk("midwait_rst_state", 32'(hz.state), 32'd0);
    chk("midwait_rst_timeout", 32'(hz.mem_timeout), 32'd0);
    tick();
    tick();
    chk("midwait_cnt_cleared", 32'(hz.mem_timeout), 32'd0);
    tick();
    chk("midwait_cnt_third", 32'(hz.mem_timeout), 32'd1);
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Redirect pulse: REDIRECT for one cycle, then back to RUN.
    hz.ex_redirect = 1'b1;
    #2;
    chk("redir_ctl", 32'(ctl()), 32'hFE);
    tick();
    chk("redir_state", 32'(hz.state), 32'd3);
    hz.ex_redirect = 1'b0;
    #2;
    chk("redir2_ctl", 32'(ctl()), 32'hF8);
    tick();
    chk("redir2_state", 32'(hz.state), 32'd0);

`ifdef HAZARD_CTRL_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("perf_stall_rst", perf_stall, 32'd0);
    chk("perf_flush_rst", perf_flush, 32'd0);
    hz.ex_mem_load = 1'b1;
    hz.ex_reg_wr   = 1'b1;
    hz.ex_rd       = 5'd5;
    hz.id_rs1      = 5'd5;
    tick();
    set_idle();
    hz.dmem_req = 1'b1;
    tick();
    tick();
    tick();
    hz.dmem_ack = 1'b1;
    tick();
    set_idle();
    tick();
    chk("perf_stall", perf_stall, 32'd4);
    hz.ex_redirect = 1'b1;
    tick();
    hz.ex_redirect = 1'b0;
    tick();
    hz.ex_redirect = 1'b1;
    tick();
    set_idle();
    tick();
    chk("perf_flush", perf_flush, 32'd2);
    chk("perf_stall_hold", perf_stall, 32'd4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
